// File: rtl/galvo_pkg.sv
// Shared definitions for the galvo scan controller: DAC channel codes,
// word/position widths, FSM state encoding and the DAC word formatter.
package galvo_pkg;

  localparam int SPI_WORD_W = 16;
  localparam int POS_W      = 11;

  localparam logic [1:0] CH_H = 2'b00;
  localparam logic [1:0] CH_V = 2'b01;

  typedef enum logic [2:0] {
    IDLE,
    SHIFT_H,
    GAP,
    SHIFT_V,
    DONE
  } state_t;

  // DAC command word: channel in the top two bits, value right-justified.
  function automatic logic [SPI_WORD_W-1:0] dac_word(input logic [1:0] ch,
                                                     input logic [POS_W-1:0] value);
    return {ch, 3'b000, value};
  endfunction

endpackage

// File: rtl/galvo_scan_ctrl_spi_word_tx.sv
// Mode-0 SPI serializer for one 16-bit DAC word, MSB first. A start while
// idle drops cs_n and presents bit 15 on the same edge; each bit spends
// SPI_DIV cycles with SCLK low and SPI_DIV cycles high. done is asserted in
// the final high-phase cycle of bit 0, so the parent can change state on the
// same edge that raises cs_n.
module spi_word_tx
  import galvo_pkg::*;
#(
  parameter int SPI_DIV = 2
) (
  input  logic                  clk_adc,
  input  logic                  rst_adc_n,
  input  logic                  start,
  input  logic [SPI_WORD_W-1:0] word,
  output logic                  sclk,
  output logic                  mosi,
  output logic                  cs_n,
  output logic                  done
);

  localparam int DIV_W = (SPI_DIV > 1) ? $clog2(SPI_DIV) : 1;
  localparam int BIT_W = $clog2(SPI_WORD_W);

  logic [DIV_W-1:0]      div_cnt;
  logic [BIT_W-1:0]      bit_cnt;
  logic [SPI_WORD_W-1:0] shift;
  logic                  phase_end;

  assign phase_end = (div_cnt == DIV_W'(SPI_DIV - 1));
  assign done      = !cs_n && sclk && phase_end && (bit_cnt == '0);

  // Serializer: load on start, then walk half-periods until bit 0 completes.
  always_ff @(posedge clk_adc or negedge rst_adc_n) begin
    if (!rst_adc_n) begin
      cs_n    <= 1'b1;
      sclk    <= 1'b0;
      mosi    <= 1'b0;
      div_cnt <= '0;
      bit_cnt <= '0;
      shift   <= '0;
    end else if (cs_n) begin
      if (start) begin
        cs_n    <= 1'b0;
        sclk    <= 1'b0;
        mosi    <= word[SPI_WORD_W-1];
        shift   <= word;
        div_cnt <= '0;
        bit_cnt <= BIT_W'(SPI_WORD_W - 1);
      end
    end else if (!phase_end) begin
      div_cnt <= div_cnt + 1'b1;
    end else begin
      div_cnt <= '0;
      if (!sclk) begin
        sclk <= 1'b1;
      end else begin
        sclk <= 1'b0;
        if (bit_cnt == '0) begin
          cs_n <= 1'b1;
          mosi <= 1'b0;
        end else begin
          bit_cnt <= bit_cnt - 1'b1;
          shift   <= {shift[SPI_WORD_W-2:0], 1'b0};
          mosi    <= shift[SPI_WORD_W-2];
        end
      end
    end
  end

endmodule

// File: rtl/galvo_scan_ctrl.sv
// Galvo raster stepper: each accepted go advances the scan position, the new
// position is committed immediately and then written to the dual-channel DAC
// (H word always, V word only when V changed or after a home).
module galvo_scan_ctrl
  import galvo_pkg::*;
#(
  parameter int H_PIXELS = 1024,
  parameter int V_LINES  = 1024,
  parameter int SPI_DIV  = 2,
  parameter int CS_GAP   = 4
) (
  input  logic             clk_adc,
  input  logic             rst_adc_n,
  input  logic             galvo_go,
  input  logic             home,
  input  logic             enable,
  input  logic             clr_overrun,
  output logic [POS_W-1:0] galvoh,
  output logic [POS_W-1:0] galvov,
  output logic             galvo_spi_done,
  output logic             frame_start,
  output logic             busy,
  output logic             overrun,
  output logic             spi_sclk,
  output logic             spi_mosi,
  output logic             spi_cs_n
);

  localparam int               GAP_W  = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;
  localparam logic [POS_W-1:0] H_LAST = POS_W'(H_PIXELS - 1);
  localparam logic [POS_W-1:0] V_LAST = POS_W'(V_LINES - 1);

  state_t                state, state_next;
  logic [GAP_W-1:0]      gap_cnt;
  logic                  gap_last;
  logic                  v_pend;
  logic                  home_pend;
  logic                  do_home;
  logic                  do_step;
  logic                  tx_start;
  logic                  tx_done;
  logic [SPI_WORD_W-1:0] tx_word;

  assign gap_last       = (gap_cnt == GAP_W'(CS_GAP - 1));
  assign busy           = (state != IDLE);
  assign galvo_spi_done = (state == DONE);

  // The V word is launched from the last GAP cycle so cs_n falls right as
  // the gap ends; any other start comes from SHIFT_H and carries the H word.
  assign tx_word = (state == GAP) ? dac_word(CH_V, galvov) : dac_word(CH_H, galvoh);

  spi_word_tx #(
    .SPI_DIV(SPI_DIV)
  ) u_tx (
    .clk_adc  (clk_adc),
    .rst_adc_n(rst_adc_n),
    .start    (tx_start),
    .word     (tx_word),
    .sclk     (spi_sclk),
    .mosi     (spi_mosi),
    .cs_n     (spi_cs_n),
    .done     (tx_done)
  );

  // State register.
  always_ff @(posedge clk_adc or negedge rst_adc_n) begin
    if (!rst_adc_n) state <= IDLE;
    else            state <= state_next;
  end

  // Next-state, request acceptance and serializer launch.
  always_comb begin
    state_next = state;
    do_home    = 1'b0;
    do_step    = 1'b0;
    tx_start   = 1'b0;
    unique case (state)
      IDLE: begin
        if (home || home_pend) begin
          do_home    = 1'b1;
          state_next = SHIFT_H;
        end else if (galvo_go && enable) begin
          do_step    = 1'b1;
          state_next = SHIFT_H;
        end
      end
      SHIFT_H: begin
        // Serializer is idle only on the first SHIFT_H cycle.
        tx_start = spi_cs_n;
        if (tx_done) state_next = GAP;
      end
      GAP: begin
        if (gap_last) begin
          if (v_pend) begin
            tx_start   = 1'b1;
            state_next = SHIFT_V;
          end else begin
            state_next = DONE;
          end
        end
      end
      SHIFT_V: begin
        if (tx_done) state_next = GAP;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Gap timer restarts every time GAP is entered.
  always_ff @(posedge clk_adc or negedge rst_adc_n) begin
    if (!rst_adc_n)          gap_cnt <= '0;
    else if (state == GAP)   gap_cnt <= gap_cnt + 1'b1;
    else                     gap_cnt <= '0;
  end

  // Position commit, V-pending bookkeeping and the frame-start pulse.
  always_ff @(posedge clk_adc or negedge rst_adc_n) begin
    if (!rst_adc_n) begin
      galvoh      <= '0;
      galvov      <= '0;
      v_pend      <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= 1'b0;
      if (do_home) begin
        galvoh      <= '0;
        galvov      <= '0;
        v_pend      <= 1'b1;
        frame_start <= 1'b1;
      end else if (do_step) begin
        if (galvoh == H_LAST) begin
          galvoh <= '0;
          v_pend <= 1'b1;
          if (galvov == V_LAST) begin
            galvov      <= '0;
            frame_start <= 1'b1;
          end else begin
            galvov <= galvov + 1'b1;
          end
        end else begin
          galvoh <= galvoh + 1'b1;
        end
      end else if (state == GAP && state_next == SHIFT_V) begin
        v_pend <= 1'b0;
      end
    end
  end

  // A home that arrives mid-sequence waits here until IDLE comes back.
  always_ff @(posedge clk_adc or negedge rst_adc_n) begin
    if (!rst_adc_n)                home_pend <= 1'b0;
    else if (do_home)              home_pend <= 1'b0;
    else if (home && state != IDLE) home_pend <= 1'b1;
  end

  // Sticky overrun: a set in the same cycle as a clear wins.
  always_ff @(posedge clk_adc or negedge rst_adc_n) begin
    if (!rst_adc_n)                              overrun <= 1'b0;
    else if (galvo_go && enable && state != IDLE) overrun <= 1'b1;
    else if (clr_overrun)                        overrun <= 1'b0;
  end

endmodule

// File: tb/tb_galvo_scan_ctrl.sv
// Scoreboard bench for galvo_scan_ctrl. The reference model tracks the scan
// position as a linear pixel index and the controller's availability as the
// cycle its current sequence finishes; expected SPI words, done cycles and
// frame-start cycles are queued at request time and popped by monitors.
module tb_galvo_scan_ctrl;

  localparam int H    = 4;
  localparam int V    = 3;
  localparam int DIV  = 2;
  localparam int GAPC = 4;
  localparam int L1   = 1 + 32*DIV + GAPC + 1;   // H-only sequence length
  localparam int L2   = L1 + 32*DIV + GAPC;      // H+V sequence length

  logic        clk_adc = 1'b0;
  logic        rst_adc_n = 1'b0;
  logic        galvo_go = 1'b0;
  logic        home = 1'b0;
  logic        enable = 1'b0;
  logic        clr_overrun = 1'b0;
  logic [10:0] galvoh, galvov;
  logic        galvo_spi_done, frame_start, busy, overrun;
  logic        spi_sclk, spi_mosi, spi_cs_n;

  galvo_scan_ctrl #(
    .H_PIXELS(H), .V_LINES(V), .SPI_DIV(DIV), .CS_GAP(GAPC)
  ) dut (
    .clk_adc(clk_adc), .rst_adc_n(rst_adc_n), .galvo_go(galvo_go), .home(home),
    .enable(enable), .clr_overrun(clr_overrun), .galvoh(galvoh), .galvov(galvov),
    .galvo_spi_done(galvo_spi_done), .frame_start(frame_start), .busy(busy),
    .overrun(overrun), .spi_sclk(spi_sclk), .spi_mosi(spi_mosi), .spi_cs_n(spi_cs_n)
  );

  always #5 clk_adc = ~clk_adc;

  int cyc = 0;
  always @(posedge clk_adc) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic unexpected(input string name, input int act);
    n_checks++;
    n_fail++;
    $display("FAIL %s: observed 0x%0h with nothing outstanding (cycle %0d)", name, act, cyc);
  endtask

  // Reference model state.
  int exp_words[$];
  int exp_done[$];
  int exp_frame[$];
  int m_idx       = 0;
  int m_last_done = -1000;
  int m_pend_slot = -1;
  bit m_ovr       = 1'b0;
  int last_j      = 0;
  int done_seen   = 0;

  // Home taking effect as if requested in drive cycle jc.
  task automatic sched_home(input int jc);
    m_idx = 0;
    exp_words.push_back(32'h0000);
    exp_words.push_back(32'h4000);
    exp_frame.push_back(jc + 1);
    exp_done.push_back(jc + L2);
    m_last_done = jc + L2;
  endtask

  task automatic step(input int jc);
    int old_v, nh, nv;
    old_v = m_idx / H;
    m_idx = (m_idx + 1) % (H*V);
    nh = m_idx % H;
    nv = m_idx / H;
    exp_words.push_back(nh);
    if (nv != old_v) begin
      exp_words.push_back(16384 + nv);
      m_last_done = jc + L2;
    end else begin
      m_last_done = jc + L1;
    end
    exp_done.push_back(m_last_done);
    if (m_idx == 0) exp_frame.push_back(jc + 1);
  endtask

  // One-cycle request; checks overrun and position once the commit edge has passed.
  task automatic req(input bit g, input bit hm, input bit en, input bit clr);
    int  j;
    bit  set_ovr;
    @(posedge clk_adc); #1;
    j = cyc;
    last_j = j;
    galvo_go = g; home = hm; enable = en; clr_overrun = clr;
    set_ovr = 1'b0;
    if (j == m_pend_slot) begin
      // the pending home is serviced in this very cycle and absorbs the request
    end else if (j > m_last_done) begin
      if (hm)            sched_home(j);
      else if (g && en)  step(j);
    end else begin
      if (g && en) set_ovr = 1'b1;
      if (hm && j > m_pend_slot) begin
        m_pend_slot = m_last_done + 1;
        sched_home(m_pend_slot);
      end
    end
    if (set_ovr)  m_ovr = 1'b1;
    else if (clr) m_ovr = 1'b0;
    @(posedge clk_adc); #1;
    galvo_go = 1'b0; home = 1'b0; clr_overrun = 1'b0;
    @(negedge clk_adc);
    chk("overrun", int'(overrun), int'(m_ovr));
    if (m_pend_slot <= j) begin
      chk("galvoh", int'(galvoh), m_idx % H);
      chk("galvov", int'(galvov), m_idx / H);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk_adc);
  endtask

  task automatic wait_idle();
    while (cyc <= m_last_done + 2) @(posedge clk_adc);
  endtask

  // SPI bus monitor: reassembles words and checks them against the queue.
  initial begin : spi_mon
    int bits, word, low_cyc;
    bit prev_sclk, prev_cs;
    bits = 0; word = 0; low_cyc = 0; prev_sclk = 1'b0; prev_cs = 1'b1;
    forever begin
      @(negedge clk_adc);
      if (!rst_adc_n) begin
        bits = 0; word = 0; low_cyc = 0; prev_sclk = 1'b0; prev_cs = 1'b1;
        continue;
      end
      if (!spi_cs_n) begin
        low_cyc++;
        if (spi_sclk && !prev_sclk) begin
          word = ((word << 1) | int'(spi_mosi)) & 32'hFFFF;
          bits++;
        end
      end else if (!prev_cs) begin
        $display("spi word 0x%04h, %0d bits, cs low %0d cycles, ends cycle %0d", word, bits, low_cyc, cyc);
        chk("spi_bits", bits, 16);
        chk("cs_low_cycles", low_cyc, 32*DIV);
        if (exp_words.size() == 0) unexpected("spi_word", word);
        else chk("spi_word", word, exp_words.pop_front());
        bits = 0; word = 0; low_cyc = 0;
      end
      prev_sclk = spi_sclk;
      prev_cs   = spi_cs_n;
    end
  end

  // Done-pulse monitor: checks the cycle of each completion.
  initial begin : done_mon
    forever begin
      @(negedge clk_adc);
      if (rst_adc_n && galvo_spi_done) begin
        done_seen++;
        $display("spi done at cycle %0d", cyc);
        if (exp_done.size() == 0) unexpected("done_cycle", cyc);
        else chk("done_cycle", cyc, exp_done.pop_front());
      end
    end
  end

  // Frame-start monitor.
  initial begin : frame_mon
    forever begin
      @(negedge clk_adc);
      if (rst_adc_n && frame_start) begin
        $display("frame start at cycle %0d", cyc);
        if (exp_frame.size() == 0) unexpected("frame_cycle", cyc);
        else chk("frame_cycle", cyc, exp_frame.pop_front());
      end
    end
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "time limit");
  end

  initial begin : stim
    int d0, rj;
    idle(3);
    #1 rst_adc_n = 1'b1;
    @(negedge clk_adc);
    chk("rst_galvoh", int'(galvoh), 0);
    chk("rst_galvov", int'(galvov), 0);
    chk("rst_cs_n", int'(spi_cs_n), 1);
    chk("rst_sclk", int'(spi_sclk), 0);
    chk("rst_mosi", int'(spi_mosi), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_overrun", int'(overrun), 0);
    chk("rst_done", int'(galvo_spi_done), 0);
    chk("rst_frame", int'(frame_start), 0);

    // Five gos across the first line wrap.
    for (int i = 0; i < 5; i++) begin
      req(1, 0, 1, 0);
      chk("busy_after_go", int'(busy), 1);
      wait_idle();
    end

    // Overrun from a go 10 cycles after the previous one; clear; disabled go.
    req(1, 0, 1, 0);
    idle(8);
    req(1, 0, 1, 0);
    wait_idle();
    req(0, 0, 1, 1);
    req(1, 0, 0, 0);
    wait_idle();

    // Walk to (3,2), then home plus go while that transfer is in flight.
    while (m_idx != 10) begin req(1, 0, 1, 0); wait_idle(); end
    req(1, 0, 1, 0);
    idle(20);
    req(1, 1, 1, 0);
    wait_idle();
    req(0, 0, 1, 1);

    // Natural frame wrap from (3,2).
    while (m_idx != 11) begin req(1, 0, 1, 0); wait_idle(); end
    req(1, 0, 1, 0);
    wait_idle();

    // Randomized mix of gos, homes, enables and clears with varied spacing.
    for (int i = 0; i < 40; i++) begin
      req(($urandom_range(0, 9) != 0), ($urandom_range(0, 9) == 0),
          ($urandom_range(0, 4) != 0), ($urandom_range(0, 5) == 0));
      idle($urandom_range(0, 160));
    end
    wait_idle();

    // Reset during the 8th SCLK high phase of a word.
    if (m_idx == H*V - 1) begin req(1, 0, 1, 0); wait_idle(); end
    req(1, 0, 1, 0);
    rj = last_j;
    while (cyc < rj + 32) @(posedge clk_adc);
    #3;
    chk("sclk_8th_high", int'(spi_sclk), 1);
    chk("cs_low_before_rst", int'(spi_cs_n), 0);
    rst_adc_n = 1'b0;
    #1;
    chk("arst_cs_n", int'(spi_cs_n), 1);
    chk("arst_galvoh", int'(galvoh), 0);
    chk("arst_galvov", int'(galvov), 0);
    chk("arst_busy", int'(busy), 0);
    exp_words.delete();
    exp_done.delete();
    exp_frame.delete();
    d0 = done_seen;
    idle(3);
    #1 rst_adc_n = 1'b1;
    m_idx = 0; m_last_done = -1000; m_pend_slot = -1; m_ovr = 1'b0;
    idle(150);
    chk("no_done_after_rst", done_seen, d0);

    // Fresh sequence after reset.
    req(1, 0, 1, 0);
    wait_idle();
    idle(5);
    chk("words_left", exp_words.size(), 0);
    chk("dones_left", exp_done.size(), 0);
    chk("frames_left", exp_frame.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/galvo_scan_ctrl.md
# galvo_scan_ctrl

Galvo-side responder to the master controller's pixel timing. It consumes `galvo_go` pulses and advances a raster position: horizontal every go, vertical on line wrap. Each new position is written to the dual-channel galvo DAC over SPI. It reports the current position and a one-cycle `galvo_spi_done` back to the master controller. Lives entirely in the ADC sample-clock domain.

## Interface
Parameters:
- `H_PIXELS`, 1024: pixels per line, 2..2048.
- `V_LINES`, 1024: lines per frame, 2..2048.
- `SPI_DIV`, 2: `clk_adc` cycles per SCLK half-period, ≥1.
- `CS_GAP`, 4: `clk_adc` cycles `cs_n` is held high between words, ≥1.

Ports (clock and reset first):
- `clk_adc`  in  1: ADC sample clock; the only clock.
- `rst_adc_n`  in  1: asynchronous, active-low reset.
- `galvo_go`  in  1: single-cycle step request.
- `home`  in  1: single-cycle request to return to (0,0).
- `enable`  in  1: level; the synchronized run flag.
- `clr_overrun`  in  1: clears `overrun`.
- `galvoh`  out  11: current horizontal position.
- `galvov`  out  11: current vertical position.
- `galvo_spi_done`  out  1: one-cycle pulse when an update sequence completes.
- `frame_start`  out  1: one-cycle pulse when position (0,0) is committed by a wrap or by `home`.
- `busy`  out  1: high whenever the FSM is not in IDLE.
- `overrun`  out  1: sticky; a `galvo_go` arrived while busy.
- `spi_sclk`, `spi_mosi`, `spi_cs_n`  out  1 each: DAC SPI bus.

## Operation
- Reset values: `galvoh`=0, `galvov`=0, `spi_cs_n`=1, `spi_sclk`=0, `spi_mosi`=0, `busy`=0, `overrun`=0, all pulses 0. The state is IDLE.
- SPI word: 16 bits, MSB first, laid out as {ch[1:0], 3'b000, value[10:0]}. ch=00 addresses H, ch=01 addresses V.
- SPI mode 0: SCLK idles low; MOSI changes while SCLK is low; the DAC samples on the rising edge.
- States:
  - IDLE:
    - `home` (while enabled or not) has priority. It commits H=0, V=0 and sets `v_pend`.
    - Else `galvo_go` with `enable`=1:
      - If H<H_PIXELS-1, then H+1.
      - Else H=0 and V+1; if V=V_LINES-1, V=0. Any V change sets `v_pend`.
    - Either request leads to SHIFT_H.
    - `galvo_go` with `enable`=0 is ignored and does not set overrun.
  - SHIFT_H: send the H word, then go to GAP.
  - GAP: hold `cs_n` high for CS_GAP cycles. Then go to SHIFT_V if `v_pend`, else DONE.
  - SHIFT_V: send the V word, clear `v_pend`, then go to GAP (which then exits to DONE).
  - DONE: pulse `galvo_spi_done` for one cycle, then return to IDLE.
- Position outputs update in the commit cycle, before the SPI transfer.
- `frame_start` pulses in the commit cycle when the result is (0,0).
- `galvo_go` while busy is dropped and sets `overrun`. `clr_overrun` clears it; a simultaneous set wins.
- `home` while busy is latched as pending and is serviced on the cycle IDLE is re-entered, ahead of any `galvo_go`.

## Timing
- The cycle after the request is accepted: `cs_n` falls and `mosi` = bit 15.
- Each bit takes 2·SPI_DIV cycles: SCLK low for SPI_DIV, then high for SPI_DIV.
- After bit 0's high phase, SCLK goes low and `cs_n` rises on the same edge.
- One word occupies 32·SPI_DIV cycles with `cs_n` low.
- H-only update latency, accept to `galvo_spi_done`: 1 + 32·SPI_DIV + CS_GAP + 1 cycles. With defaults this is 70.
- H+V update adds 32·SPI_DIV + CS_GAP cycles; with defaults, 138 total.
- The master issues go every PIXEL_SIZE/2 cycles. That interval must exceed the H+V latency, otherwise `overrun` flags it.
- Asynchronous reset mid-transfer: `cs_n` goes high immediately, positions return to 0, and no done pulse is issued.

## Structure
- Package `galvo_pkg`:
  - channel codes `CH_H`=2'b00, `CH_V`=2'b01;
  - `SPI_WORD_W`=16;
  - `POS_W`=11;
  - state enum {IDLE, SHIFT_H, GAP, SHIFT_V, DONE}.
- Sub-module `spi_word_tx`: a 16-bit serializer with divider.
  - Inputs: `start` and `word`.
  - Outputs: `sclk`, `mosi`, `cs_n`, `done`.
  - Same clock and reset as the parent.
  - The parent FSM sequences words and the gap.

## Test plan
- Reset, then one `galvo_go` with `enable`=1:
  - `galvoh`=1 next cycle;
  - one SPI word 0x0001;
  - `galvo_spi_done` exactly 70 cycles after the go;
  - `galvov`=0.
- H_PIXELS=4, five gos:
  - 4th go yields H=0, V=1 and two words 0x0000 then 0x4001, with done at 138 cycles;
  - 5th go gives word 0x0001.
- H_PIXELS=2, V_LINES=2, four gos:
  - the 4th returns to (0,0), pulses `frame_start`, and sends 0x0000 then 0x4000.
- `galvo_go` 10 cycles after a prior go:
  - the second go is ignored and `overrun`=1;
  - `clr_overrun` returns it to 0;
  - `galvo_go` with `enable`=0 leaves the position and `overrun` unchanged.
- `home` asserted mid-transfer at position (3,2):
  - the current sequence completes;
  - then (0,0) is committed and words 0x0000 and 0x4000 are sent;
  - a go in the same cycle as home is ignored.
- Assert `rst_adc_n` low during the 8th SCLK of a word:
  - `cs_n`=1 and position 0 asynchronously;
  - no `galvo_spi_done` pulse.
